// File: rtl/trisc_pkg.sv
// Shared TRISC definitions: opcodes, control-strobe bit positions and default widths.
// Used by both the control unit and the datapath.
package trisc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int OPC_W_DEF  = 4;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_INC = 4'd5;
  localparam logic [3:0] OP_CLR = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JPZ = 4'd8;
  localparam logic [3:0] OP_JPN = 4'd9;
  localparam logic [3:0] OP_HLT = 4'd10;

  localparam int CTRL_W    = 15;
  localparam int C_MAR_PC  = 0;
  localparam int C_PC_INC  = 1;
  localparam int C_MDR_RD  = 2;
  localparam int C_IR_LD   = 3;
  localparam int C_MAR_IR  = 4;
  localparam int C_ACC_LD  = 5;
  localparam int C_MEM_WR  = 6;
  localparam int C_ADD     = 7;
  localparam int C_SUB     = 8;
  localparam int C_XOR     = 9;
  localparam int C_INC     = 10;
  localparam int C_CLR     = 11;
  localparam int C_JMP     = 12;
  localparam int C_JPZ     = 13;
  localparam int C_JPN     = 14;

  // One-hot ALU operation vector, already priority-resolved
  localparam int ALU_OPS = 6;
  localparam int A_CLR   = 0;
  localparam int A_LD    = 1;
  localparam int A_ADD   = 2;
  localparam int A_SUB   = 3;
  localparam int A_XOR   = 4;
  localparam int A_INC   = 5;

  typedef logic [ALU_OPS-1:0] alu_op_t;

endpackage

// File: rtl/trisc_alu.sv
// Combinational TRISC ALU: applies one priority-resolved operation to ACC and MDR.
module trisc_alu
  import trisc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0]  acc,
  input  logic [DATA_W-1:0]  mdr,
  input  logic [ALU_OPS-1:0] op,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic               neg
);

  always_comb begin
    result = acc;
    if (op[A_CLR])      result = '0;
    else if (op[A_LD])  result = mdr;
    else if (op[A_ADD]) result = acc + mdr;
    else if (op[A_SUB]) result = acc - mdr;
    else if (op[A_XOR]) result = acc ^ mdr;
    else if (op[A_INC]) result = acc + DATA_W'(1);
    zero = (result == '0);
    neg  = result[DATA_W-1];
  end

endmodule

// File: rtl/trisc_datapath.sv
// TRISC datapath: PC/MAR/MDR/IR/ACC, flags, memory and strobe conflict resolution.
// Executes the control unit's per-cycle strobes; a program-load port fills memory while stopped.
module trisc_datapath
  import trisc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
) (
  input  logic              SysClock,
  input  logic              Resetn,
  input  logic [CTRL_W-1:0] Ctrl,
  input  logic              ProgLoad,
  input  logic              ProgWe,
  input  logic [ADDR_W-1:0] ProgAddr,
  input  logic [DATA_W-1:0] ProgData,
  output logic [OPC_W-1:0]  Opcode,
  output logic [DATA_W-1:0] Acc,
  output logic [ADDR_W-1:0] Pc,
  output logic              Zf,
  output logic              Nf,
  output logic              CtrlErr
);

  if (OPC_W != 4 || DATA_W != OPC_W + ADDR_W) begin : g_param_err
    $error("trisc_datapath: OPC_W must be 4 and DATA_W must equal OPC_W+ADDR_W");
  end

  logic [ADDR_W-1:0] pc, mar, ir_addr;
  logic [DATA_W-1:0] mdr, ir, acc;
  logic              zf, nf, ctrl_err;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ALU_OPS-1:0] alu_op;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero, alu_neg;
  logic               acc_we, acc_conf;
  logic [2:0]         jmp_taken_vec;
  logic               jmp_taken, pc_conf, mar_conf;

  assign ir_addr = ir[ADDR_W-1:0];

  always_comb begin
    alu_op = '0;
    if (Ctrl[C_CLR])         alu_op[A_CLR] = 1'b1;
    else if (Ctrl[C_ACC_LD]) alu_op[A_LD]  = 1'b1;
    else if (Ctrl[C_ADD])    alu_op[A_ADD] = 1'b1;
    else if (Ctrl[C_SUB])    alu_op[A_SUB] = 1'b1;
    else if (Ctrl[C_XOR])    alu_op[A_XOR] = 1'b1;
    else if (Ctrl[C_INC])    alu_op[A_INC] = 1'b1;
  end

  assign acc_we   = |alu_op;
  assign acc_conf = $countones({Ctrl[C_CLR], Ctrl[C_ACC_LD], Ctrl[C_ADD],
                                Ctrl[C_SUB], Ctrl[C_XOR], Ctrl[C_INC]}) > 1;

  // Only jumps that are actually taken compete with each other or with increment
  assign jmp_taken_vec = {Ctrl[C_JPN] & nf, Ctrl[C_JPZ] & zf, Ctrl[C_JMP]};
  assign jmp_taken     = |jmp_taken_vec;
  assign pc_conf       = (Ctrl[C_PC_INC] & jmp_taken) | ($countones(jmp_taken_vec) > 1);
  assign mar_conf      = Ctrl[C_MAR_PC] & Ctrl[C_MAR_IR];

  trisc_alu #(.DATA_W(DATA_W)) u_alu (
    .acc    (acc),
    .mdr    (mdr),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .neg    (alu_neg)
  );

  always_ff @(posedge SysClock or negedge Resetn) begin
    if (!Resetn) begin
      pc       <= '0;
      mar      <= '0;
      mdr      <= '0;
      ir       <= '0;
      acc      <= '0;
      zf       <= 1'b1;
      nf       <= 1'b0;
      ctrl_err <= 1'b0;
    end else if (ProgLoad) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (Ctrl[C_MAR_IR])      mar <= ir_addr;
      else if (Ctrl[C_MAR_PC]) mar <= pc;
      if (jmp_taken)           pc <= ir_addr;
      else if (Ctrl[C_PC_INC]) pc <= pc + ADDR_W'(1);
      if (Ctrl[C_MDR_RD])      mdr <= mem[mar];
      if (Ctrl[C_IR_LD])       ir <= mdr;
      if (acc_we) begin
        acc <= alu_result;
        zf  <= alu_zero;
        nf  <= alu_neg;
      end
      if (acc_conf | pc_conf | mar_conf) ctrl_err <= 1'b1;
    end
  end

  // Memory is deliberately outside the reset domain so a program survives Resetn
  always_ff @(posedge SysClock) begin
    if (ProgLoad) begin
      if (ProgWe) mem[ProgAddr] <= ProgData;
    end else if (Ctrl[C_MEM_WR]) begin
      mem[mar] <= acc;
    end
  end

  assign Opcode  = ir[DATA_W-1 -: OPC_W];
  assign Acc     = acc;
  assign Pc      = pc;
  assign Zf      = zf;
  assign Nf      = nf;
  assign CtrlErr = ctrl_err;

endmodule

// File: tb/tb_trisc_datapath.sv
// Scoreboard bench for trisc_datapath: driver pushes expected outputs, monitor pops and compares.
module tb_trisc_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] ctrl = '0;
  logic        prog_load = 1'b0, prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [3:0]  opcode;
  logic [7:0]  acc;
  logic [3:0]  pc;
  logic        zf, nf, ctrl_err;

  trisc_datapath dut (
    .SysClock (clk),
    .Resetn   (rst_n),
    .Ctrl     (ctrl),
    .ProgLoad (prog_load),
    .ProgWe   (prog_we),
    .ProgAddr (prog_addr),
    .ProgData (prog_data),
    .Opcode   (opcode),
    .Acc      (acc),
    .Pc       (pc),
    .Zf       (zf),
    .Nf       (nf),
    .CtrlErr  (ctrl_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [18:0] exp;
  } item_t;

  item_t sb[$];
  event  sample_ev;
  int    n_checks = 0;
  int    n_pass = 0;

  // Reference machine state
  logic [7:0] m_mem [16];
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_mdr, m_ir, m_acc;
  bit         m_zf, m_nf, m_err;

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_acc = 0;
    m_zf = 1; m_nf = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic [14:0] c, input bit pl, input bit we,
                            input logic [3:0] pa, input logic [7:0] pd);
    logic [3:0] n_pc, n_mar;
    logic [7:0] n_mdr, n_ir, n_acc;
    bit         acc_w, t12, t13, t14;
    int         n_acc_ops, n_jumps;
    if (pl) begin
      if (we) m_mem[pa] = pd;
      m_pc = 0;
      m_ir = 0;
      return;
    end
    n_mar = m_mar;
    if (c[4]) n_mar = m_ir[3:0];
    else if (c[0]) n_mar = m_pc;
    t12 = c[12]; t13 = c[13] && m_zf; t14 = c[14] && m_nf;
    n_jumps = int'(t12) + int'(t13) + int'(t14);
    n_pc = m_pc;
    if (n_jumps > 0) n_pc = m_ir[3:0];
    else if (c[1]) n_pc = m_pc + 4'd1;
    n_mdr = c[2] ? m_mem[m_mar] : m_mdr;
    n_ir  = c[3] ? m_mdr : m_ir;
    n_acc_ops = int'(c[5]) + int'(c[7]) + int'(c[8]) + int'(c[9]) + int'(c[10]) + int'(c[11]);
    acc_w = (n_acc_ops > 0);
    n_acc = m_acc;
    if (c[11])      n_acc = 8'h00;
    else if (c[5])  n_acc = m_mdr;
    else if (c[7])  n_acc = m_acc + m_mdr;
    else if (c[8])  n_acc = m_acc - m_mdr;
    else if (c[9])  n_acc = m_acc ^ m_mdr;
    else if (c[10]) n_acc = m_acc + 8'd1;
    if (c[6]) m_mem[m_mar] = m_acc;
    if (n_acc_ops > 1 || n_jumps > 1 || (c[1] && n_jumps > 0) || (c[0] && c[4])) m_err = 1;
    if (acc_w) begin
      m_zf = (n_acc == 8'h00);
      m_nf = n_acc[7];
    end
    m_pc = n_pc; m_mar = n_mar; m_mdr = n_mdr; m_ir = n_ir; m_acc = n_acc;
  endtask

  task automatic push_model(input string name);
    item_t it;
    it.name = name;
    it.exp  = {m_ir[7:4], m_acc, m_pc, m_zf, m_nf, m_err};
    sb.push_back(it);
  endtask

  task automatic push_const(input string name, input logic [3:0] op, input logic [7:0] a,
                            input logic [3:0] p, input bit z, input bit n, input bit e);
    item_t it;
    it.name = name;
    it.exp  = {op, a, p, z, n, e};
    sb.push_back(it);
  endtask

  task automatic check_now(input string name, input logic [3:0] op, input logic [7:0] a,
                           input logic [3:0] p, input bit z, input bit n, input bit e);
    logic [18:0] exp_v, act_v;
    exp_v = {op, a, p, z, n, e};
    act_v = {opcode, acc, pc, zf, nf, ctrl_err};
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s (direct): got op=%h acc=%h pc=%h z=%b n=%b err=%b, expected op=%h acc=%h pc=%h z=%b n=%b err=%b",
                  name, act_v[18:15], act_v[14:7], act_v[6:3], act_v[2], act_v[1], act_v[0],
                  op, a, p, z, n, e);
  endtask

  // Inputs change at posedge+1; the model advances once the edge has happened
  task automatic step(input logic [14:0] c, input bit pl = 0, input bit we = 0,
                      input logic [3:0] pa = 0, input logic [7:0] pd = 0);
    ctrl = c; prog_load = pl; prog_we = we; prog_addr = pa; prog_data = pd;
    @(posedge clk);
    #1;
    model_edge(c, pl, we, pa, pd);
    push_model("step");
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    step(15'h0000, 1'b1, 1'b1, a, d);
  endtask

  initial begin
    item_t       it;
    logic [18:0] act;
    forever begin
      @(negedge clk or sample_ev);
      while (sb.size() > 0) begin
        it  = sb.pop_front();
        act = {opcode, acc, pc, zf, nf, ctrl_err};
        n_checks++;
        if (act === it.exp) n_pass++;
        else $display("FAIL %s: got op=%h acc=%h pc=%h z=%b n=%b err=%b, expected op=%h acc=%h pc=%h z=%b n=%b err=%b",
                      it.name, act[18:15], act[14:7], act[6:3], act[2], act[1], act[0],
                      it.exp[18:15], it.exp[14:7], it.exp[6:3], it.exp[2], it.exp[1], it.exp[0]);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0);
    push_const("reset", 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Program image for the directed sequences
    load(4'h0, 8'h05);
    load(4'h5, 8'h80);
    load(4'h1, 8'hFF);
    load(4'h2, 8'h01);
    load(4'h3, 8'h8C);

    // LDA 5 through fetch / decode / execute strobes
    step(15'h0003); step(15'h0004); step(15'h0008);
    step(15'h0010); step(15'h0004); step(15'h0020);
    push_const("lda_exec", 4'h0, 8'h80, 4'h1, 1'b0, 1'b1, 1'b0);

    // ACC=FF, MDR=01: add wraps to zero, then subtract back to FF
    step(15'h0001); step(15'h0004); step(15'h0020);
    step(15'h0002); step(15'h0001); step(15'h0004);
    step(15'h0080);
    push_const("add_wrap", 4'h0, 8'h00, 4'h2, 1'b1, 1'b0, 1'b0);
    step(15'h0100);
    push_const("sub_wrap", 4'h0, 8'hFF, 4'h2, 1'b0, 1'b1, 1'b0);

    // IR=8C: JPZ not taken, then taken; PC wrap on increment
    step(15'h0002); step(15'h0001); step(15'h0004); step(15'h0008);
    step(15'h2000);
    push_const("jpz_not_taken", 4'h8, 8'hFF, 4'h3, 1'b0, 1'b1, 1'b0);
    step(15'h0800);
    step(15'h2000);
    push_const("jpz_taken", 4'h8, 8'h00, 4'hC, 1'b1, 1'b0, 1'b0);
    step(15'h0002); step(15'h0002); step(15'h0002);
    push_const("pc_at_f", 4'h8, 8'h00, 4'hF, 1'b1, 1'b0, 1'b0);
    step(15'h0002);
    push_const("pc_wrap", 4'h8, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0);

    // ACC conflict: clear beats load, error is sticky
    step(15'h0820);
    push_const("acc_conflict", 4'h8, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
    step(15'h0000); step(15'h0400);
    push_const("err_sticky", 4'h8, 8'h01, 4'h0, 1'b0, 1'b0, 1'b1);

    // Randomized phase over a fully known memory image
    for (int a = 0; a < 16; a++) load(4'(a), 8'($urandom));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0)
        step(15'($urandom), 1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
      else
        step(15'($urandom & $urandom));
    end

    // Reset mid-instruction, between edges; memory must survive
    load(4'h0, 8'h07);
    load(4'h7, 8'h5A);
    step(15'h0003);
    step(15'h0004);
    @(negedge clk);
    ctrl = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_now("async_reset", 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0);
    push_const("async_reset", 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0);
    -> sample_ev;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(15'h0003); step(15'h0004); step(15'h0008);
    step(15'h0010); step(15'h0004); step(15'h0020);
    push_const("lda_after_reset", 4'h0, 8'h5A, 4'h1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass != n_checks) $display("FAIL: %0d check(s) failed", n_checks - n_pass);
    else $display("PASS");
    $finish;
  end

endmodule
